// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// the baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count. Pointers wrap naturally;
// the count is what distinguishes full from empty.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Requests against a full or empty FIFO are silently dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes enter a small FIFO over valid/ready and are
// serialised LSB first with one start and one stop bit on a registered tx line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [UART_DATA_BITS-1:0]     data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                   state_q, state_d;
    logic [BAUD_W-1:0]           baud_q, baud_d;
    logic [UART_BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        tx_q, tx_d;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [UART_DATA_BITS-1:0]   fifo_rdata;
    logic                        bit_done;

    assign ready     = !fifo_full;
    assign fifo_push = valid && ready;
    assign bit_done  = (baud_q == BAUD_LAST);

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // The line level follows the current state, so tx lags the state by one clock.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx #(
        .CLK_FREQ   (16),
        .BAUD       (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte and hold it until accepted; returns cycles spent stalled.
    task automatic send(input logic [7:0] b, output int waited);
        data   = b;
        valid  = 1'b1;
        waited = 0;
        while (!ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!ready) chk("send_timeout", 32'(ready), 32'd1);
        tick();
        valid = 1'b0;
    endtask

    // Called on the first clock of a start bit; checks all 40 line clocks of a frame.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("%s_clk%0d", tag, i), 32'(tx), 32'(frame[i / 4]));
            tick();
        end
    endtask

    // Receiver model: find a start edge, then sample each bit at mid-bit.
    task automatic rx_byte(output logic [7:0] b, output logic framed);
        int n;
        n = 0;
        b = '0;
        while (tx !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        framed = (tx === 1'b0);
        repeat (2) tick();
        framed = framed && (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            b[i] = tx;
        end
        repeat (4) tick();
        framed = framed && (tx === 1'b1);
    endtask

    initial begin
        int         w;
        logic [7:0] rb;
        logic       fr;
        logic       saw_low;
        logic [7:0] burst [6];

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;

        // 1: reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_tx_%0d", i), 32'(tx), 32'd1);
            chk($sformatf("rst_ready_%0d", i), 32'(ready), 32'd1);
            chk($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
            chk($sformatf("rst_count_%0d", i), 32'(fifo_count), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        // 2: single byte, latency and framing
        send(8'h55, w);
        chk("b55_busy", 32'(busy), 32'd1);
        chk("b55_count", 32'(fifo_count), 32'd1);
        tick();
        chk("b55_tx_n1", 32'(tx), 32'd1);
        chk("b55_count_n1", 32'(fifo_count), 32'd0);
        tick();
        check_frame(8'h55, "b55");
        chk("b55_busy_end", 32'(busy), 32'd0);
        chk("b55_tx_end", 32'(tx), 32'd1);

        // 3: four pushes on consecutive cycles, contiguous frames
        fork
            begin
                send(8'h44, w);
                chk("q4_wait0", 32'(w), 32'd0);
                send(8'h4C, w);
                chk("q4_wait1", 32'(w), 32'd0);
                send(8'h52, w);
                chk("q4_wait2", 32'(w), 32'd0);
                send(8'h55, w);
                chk("q4_wait3", 32'(w), 32'd0);
                chk("q4_count", 32'(fifo_count), 32'd3);
            end
            begin
                repeat (3) tick();
                check_frame(8'h44, "q4_f0");
                check_frame(8'h4C, "q4_f1");
                check_frame(8'h52, "q4_f2");
                check_frame(8'h55, "q4_f3");
            end
        join
        chk("q4_busy_end", 32'(busy), 32'd0);
        chk("q4_count_end", 32'(fifo_count), 32'd0);

        // 4: six bytes held back-to-back, backpressure once full
        burst[0] = 8'h11; burst[1] = 8'hE7; burst[2] = 8'h80;
        burst[3] = 8'h01; burst[4] = 8'h9A; burst[5] = 8'h6D;
        fork
            begin
                for (int i = 0; i < 5; i++) send(burst[i], w);
                chk("bp_full_count", 32'(fifo_count), 32'd4);
                chk("bp_full_ready", 32'(ready), 32'd0);
                send(burst[5], w);
                chk("bp_stall_cycles", 32'(w), 32'd37);
                chk("bp_refill_count", 32'(fifo_count), 32'd4);
            end
            begin
                repeat (3) tick();
                for (int i = 0; i < 6; i++) check_frame(burst[i], $sformatf("bp_f%0d", i));
            end
        join
        chk("bp_busy_end", 32'(busy), 32'd0);
        chk("bp_tx_end", 32'(tx), 32'd1);

        // 5: reset during data bit 3 discards the frame and the queue
        send(8'hA5, w);
        send(8'h11, w);
        repeat (18) tick();
        chk("abort_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        tick();
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_count", 32'(fifo_count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        chk("abort_quiet", 32'(saw_low), 32'd0);
        send(8'h3C, w);
        repeat (2) tick();
        check_frame(8'h3C, "b3c");

        // 6: loopback through a receiver model
        fork
            begin
                send(8'h00, w);
                send(8'hFF, w);
                send(8'h52, w);
            end
            begin
                rx_byte(rb, fr);
                chk("lb0_data", 32'(rb), 32'h00);
                chk("lb0_frame", 32'(fr), 32'd1);
                rx_byte(rb, fr);
                chk("lb1_data", 32'(rb), 32'hFF);
                chk("lb1_frame", 32'(fr), 32'd1);
                rx_byte(rb, fr);
                chk("lb2_data", 32'(rb), 32'h52);
                chk("lb2_frame", 32'(fr), 32'd1);
            end
        join
        repeat (4) tick();
        chk("lb_busy_end", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
